// File: rtl/req_ack_multi_tracker.sv
// rtl/req_ack_multi_tracker.sv - multi-channel req/ack responder with gap enforcement, counters and outstanding tracking
module req_ack_multi_tracker #(
    parameter int CHANNELS = 2,
    parameter int LATENCY  = 4,
    parameter int MIN_GAP  = 8,
    parameter int CNT_W    = 8,
    localparam int OUT_W   = $clog2(LATENCY + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       req,
    input  logic                      clr_cnt,
    output logic [CHANNELS-1:0]       ack,
    output logic [CHANNELS-1:0]       drop,
    output logic [CHANNELS-1:0]       busy,
    output logic [CHANNELS*CNT_W-1:0] req_cnt,
    output logic [CHANNELS*CNT_W-1:0] ack_cnt,
    output logic [CHANNELS*OUT_W-1:0] outstanding
);

    localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

    typedef enum logic {IDLE, GAP} state_t;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_t             state;
        logic [GAP_W-1:0]   gap_cnt;
        logic [LATENCY-1:0] dly;
        logic [CNT_W-1:0]   rc;
        logic [CNT_W-1:0]   ac;
        logic [OUT_W-1:0]   outs;
        logic               drop_r;
        logic               accept;
        logic               ack_now;

        assign accept  = req[i] && (state == IDLE);
        assign ack_now = dly[LATENCY-1];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state   <= IDLE;
                gap_cnt <= '0;
                dly     <= '0;
                rc      <= '0;
                ac      <= '0;
                outs    <= '0;
                drop_r  <= 1'b0;
            end else begin
                drop_r <= req[i] && (state == GAP);

                // Stage k holds accepts from k+1 cycles ago; the last stage is the ack
                dly[0] <= accept;
                for (int k = 1; k < LATENCY; k++) begin
                    dly[k] <= dly[k-1];
                end

                case (state)
                    IDLE: begin
                        if (req[i]) begin
                            gap_cnt <= GAP_W'(MIN_GAP - 1);
                            if (MIN_GAP > 1) state <= GAP;
                        end
                    end
                    GAP: begin
                        gap_cnt <= gap_cnt - 1'b1;
                        if (gap_cnt == GAP_W'(1)) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase

                if (accept && !ack_now)      outs <= outs + 1'b1;
                else if (!accept && ack_now) outs <= outs - 1'b1;

                if (clr_cnt)                      rc <= CNT_W'(accept);
                else if (accept && (rc != '1))    rc <= rc + 1'b1;

                if (clr_cnt)                      ac <= CNT_W'(ack_now);
                else if (ack_now && (ac != '1))   ac <= ac + 1'b1;
            end
        end

        assign ack[i]                        = ack_now;
        assign drop[i]                       = drop_r;
        assign busy[i]                       = (state == GAP);
        assign req_cnt[i*CNT_W +: CNT_W]     = rc;
        assign ack_cnt[i*CNT_W +: CNT_W]     = ac;
        assign outstanding[i*OUT_W +: OUT_W] = outs;

`ifdef FORMAL
        int   since_acc;
        logic cnt_clean;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                since_acc <= MIN_GAP;
                cnt_clean <= 1'b1;
            end else begin
                since_acc <= accept ? 1 : ((since_acc < MIN_GAP) ? since_acc + 1 : since_acc);
                if (clr_cnt) cnt_clean <= 1'b0;
            end
        end
        always_comb begin
            if (!rst) begin
                assert (!accept || (since_acc >= MIN_GAP));
                assert (!(cnt_clean && (rc == ac) && (rc != '1)) || (outs == '0));
            end
        end
        assert property (@(posedge clk) disable iff (rst) ack_now |-> $past(accept, LATENCY));
`endif
    end

endmodule

// File: tb/tb_req_ack_multi_tracker.sv
// tb/tb_req_ack_multi_tracker.sv - directed self-checking bench for req_ack_multi_tracker
module tb_req_ack_multi_tracker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr_cnt = 1'b0;
    logic [1:0]  req_a = '0, req_b = '0, req_c = '0;

    logic [1:0]  ack_a, drop_a, busy_a;
    logic [15:0] rcnt_a, acnt_a;
    logic [5:0]  out_a;
    logic [1:0]  ack_b, drop_b, busy_b;
    logic [15:0] rcnt_b, acnt_b;
    logic [5:0]  out_b;
    logic [1:0]  ack_c, drop_c, busy_c;
    logic [3:0]  rcnt_c, acnt_c;
    logic [5:0]  out_c;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    req_ack_multi_tracker u_dut (
        .clk(clk), .rst(rst), .req(req_a), .clr_cnt(clr_cnt),
        .ack(ack_a), .drop(drop_a), .busy(busy_a),
        .req_cnt(rcnt_a), .ack_cnt(acnt_a), .outstanding(out_a)
    );

    req_ack_multi_tracker #(.MIN_GAP(2), .LATENCY(4)) u_gap2 (
        .clk(clk), .rst(rst), .req(req_b), .clr_cnt(clr_cnt),
        .ack(ack_b), .drop(drop_b), .busy(busy_b),
        .req_cnt(rcnt_b), .ack_cnt(acnt_b), .outstanding(out_b)
    );

    req_ack_multi_tracker #(.CNT_W(2)) u_cnt2 (
        .clk(clk), .rst(rst), .req(req_c), .clr_cnt(clr_cnt),
        .ack(ack_c), .drop(drop_c), .busy(busy_c),
        .req_cnt(rcnt_c), .ack_cnt(acnt_c), .outstanding(out_c)
    );

    // Cycle 0 of each test is the clock period in which rst drops
    task automatic start_test();
        rst = 1'b1; clr_cnt = 1'b0; req_a = '0; req_b = '0; req_c = '0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_a = '0; req_b = '0; req_c = '0; clr_cnt = 1'b0;
        @(posedge clk); @(negedge clk);
        total++; if (ack_a !== 2'b00)  begin bad++; $display("FAIL reset_ack got=%b exp=00", ack_a); end
        total++; if (drop_a !== 2'b00) begin bad++; $display("FAIL reset_drop got=%b exp=00", drop_a); end
        total++; if (busy_a !== 2'b00) begin bad++; $display("FAIL reset_busy got=%b exp=00", busy_a); end
        total++; if (rcnt_a !== 16'd0) begin bad++; $display("FAIL reset_req_cnt got=%h exp=0", rcnt_a); end
        total++; if (acnt_a !== 16'd0) begin bad++; $display("FAIL reset_ack_cnt got=%h exp=0", acnt_a); end
        total++; if (out_a !== 6'd0)   begin bad++; $display("FAIL reset_outstanding got=%h exp=0", out_a); end
    endtask

    task automatic test_single();
        logic       e_ack;
        logic [2:0] e_out;
        start_test();
        for (int cyc = 0; cyc < 10; cyc++) begin
            req_a = (cyc == 2) ? 2'b01 : 2'b00;
            @(negedge clk);
            e_ack = (cyc == 6);
            e_out = (cyc >= 3 && cyc <= 6) ? 3'd1 : 3'd0;
            total++; if (ack_a !== {1'b0, e_ack}) begin bad++; $display("FAIL single_ack cyc=%0d got=%b exp=0%b", cyc, ack_a, e_ack); end
            total++; if (out_a[2:0] !== e_out)   begin bad++; $display("FAIL single_out0 cyc=%0d got=%0d exp=%0d", cyc, out_a[2:0], e_out); end
            next_cycle();
        end
        req_a = '0;
        @(negedge clk);
        total++; if (rcnt_a[7:0] !== 8'd1) begin bad++; $display("FAIL single_req_cnt0 got=%0d exp=1", rcnt_a[7:0]); end
        total++; if (acnt_a[7:0] !== 8'd1) begin bad++; $display("FAIL single_ack_cnt0 got=%0d exp=1", acnt_a[7:0]); end
    endtask

    task automatic test_gap();
        logic e_ack, e_drop, e_busy;
        start_test();
        for (int cyc = 0; cyc < 17; cyc++) begin
            req_a = (cyc == 2 || cyc == 5 || cyc == 10) ? 2'b01 : 2'b00;
            @(negedge clk);
            e_ack  = (cyc == 6 || cyc == 14);
            e_drop = (cyc == 6);
            e_busy = (cyc >= 3 && cyc <= 9) || (cyc >= 11);
            total++; if (ack_a[0] !== e_ack)   begin bad++; $display("FAIL gap_ack0 cyc=%0d got=%b exp=%b", cyc, ack_a[0], e_ack); end
            total++; if (drop_a[0] !== e_drop) begin bad++; $display("FAIL gap_drop0 cyc=%0d got=%b exp=%b", cyc, drop_a[0], e_drop); end
            total++; if (busy_a[0] !== e_busy) begin bad++; $display("FAIL gap_busy0 cyc=%0d got=%b exp=%b", cyc, busy_a[0], e_busy); end
            next_cycle();
        end
        req_a = '0;
        @(negedge clk);
        total++; if (rcnt_a[7:0] !== 8'd2) begin bad++; $display("FAIL gap_req_cnt0 got=%0d exp=2", rcnt_a[7:0]); end
        total++; if (acnt_a[7:0] !== 8'd2) begin bad++; $display("FAIL gap_ack_cnt0 got=%0d exp=2", acnt_a[7:0]); end
    endtask

    task automatic test_two_channels();
        logic [1:0] e_ack;
        start_test();
        for (int cyc = 0; cyc < 10; cyc++) begin
            req_a = (cyc == 3) ? 2'b11 : 2'b00;
            @(negedge clk);
            e_ack = (cyc == 7) ? 2'b11 : 2'b00;
            total++; if (ack_a !== e_ack) begin bad++; $display("FAIL dual_ack cyc=%0d got=%b exp=%b", cyc, ack_a, e_ack); end
            next_cycle();
        end
        req_a = '0;
        @(negedge clk);
        total++; if (acnt_a !== {8'd1, 8'd1}) begin bad++; $display("FAIL dual_ack_cnt got=%h exp=0101", acnt_a); end
        total++; if (rcnt_a !== {8'd1, 8'd1}) begin bad++; $display("FAIL dual_req_cnt got=%h exp=0101", rcnt_a); end
        total++; if (out_a !== 6'd0)          begin bad++; $display("FAIL dual_outstanding got=%h exp=0", out_a); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] e_out_tab [0:10];
        logic       e_ack, e_busy;
        e_out_tab = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd1, 3'd1, 3'd0, 3'd0};
        start_test();
        for (int cyc = 0; cyc < 11; cyc++) begin
            req_b = (cyc == 0 || cyc == 2 || cyc == 4) ? 2'b01 : 2'b00;
            @(negedge clk);
            e_ack  = (cyc == 4 || cyc == 6 || cyc == 8);
            e_busy = (cyc == 1 || cyc == 3 || cyc == 5);
            total++; if (ack_b[0] !== e_ack)          begin bad++; $display("FAIL b2b_ack0 cyc=%0d got=%b exp=%b", cyc, ack_b[0], e_ack); end
            total++; if (busy_b[0] !== e_busy)        begin bad++; $display("FAIL b2b_busy0 cyc=%0d got=%b exp=%b", cyc, busy_b[0], e_busy); end
            total++; if (drop_b !== 2'b00)            begin bad++; $display("FAIL b2b_drop cyc=%0d got=%b exp=00", cyc, drop_b); end
            total++; if (out_b[2:0] !== e_out_tab[cyc]) begin bad++; $display("FAIL b2b_out0 cyc=%0d got=%0d exp=%0d", cyc, out_b[2:0], e_out_tab[cyc]); end
            next_cycle();
        end
        req_b = '0;
        total++; if (rcnt_b[7:0] !== 8'd3) begin bad++; $display("FAIL b2b_req_cnt0 got=%0d exp=3", rcnt_b[7:0]); end
    endtask

    task automatic test_saturate_clear();
        start_test();
        for (int cyc = 0; cyc < 42; cyc++) begin
            req_c   = (cyc % 8 == 0) ? 2'b01 : 2'b00;
            clr_cnt = (cyc == 40);
            @(negedge clk);
            if (cyc == 25) begin
                total++; if (rcnt_c[1:0] !== 2'd3) begin bad++; $display("FAIL sat_req_cnt4 got=%0d exp=3", rcnt_c[1:0]); end
            end
            if (cyc == 34) begin
                total++; if (rcnt_c[1:0] !== 2'd3) begin bad++; $display("FAIL sat_req_cnt5 got=%0d exp=3", rcnt_c[1:0]); end
            end
            if (cyc == 38) begin
                total++; if (acnt_c[1:0] !== 2'd3) begin bad++; $display("FAIL sat_ack_cnt got=%0d exp=3", acnt_c[1:0]); end
            end
            if (cyc == 41) begin
                total++; if (rcnt_c[1:0] !== 2'd1) begin bad++; $display("FAIL clr_req_cnt got=%0d exp=1", rcnt_c[1:0]); end
                total++; if (acnt_c[1:0] !== 2'd0) begin bad++; $display("FAIL clr_ack_cnt got=%0d exp=0", acnt_c[1:0]); end
                total++; if (out_c[2:0] !== 3'd1)  begin bad++; $display("FAIL clr_outstanding got=%0d exp=1", out_c[2:0]); end
            end
            next_cycle();
        end
        req_c = '0; clr_cnt = 1'b0;
    endtask

    task automatic test_mid_reset();
        logic e_ack;
        start_test();
        for (int cyc = 0; cyc < 13; cyc++) begin
            req_a = (cyc == 2 || cyc == 7) ? 2'b01 : 2'b00;
            if (cyc == 4) rst = 1'b1;
            if (cyc == 5) rst = 1'b0;
            @(negedge clk);
            e_ack = (cyc == 11);
            total++; if (ack_a[0] !== e_ack) begin bad++; $display("FAIL rst_ack0 cyc=%0d got=%b exp=%b", cyc, ack_a[0], e_ack); end
            if (cyc == 5) begin
                total++; if (rcnt_a !== 16'd0) begin bad++; $display("FAIL rst_req_cnt got=%h exp=0", rcnt_a); end
                total++; if (acnt_a !== 16'd0) begin bad++; $display("FAIL rst_ack_cnt got=%h exp=0", acnt_a); end
                total++; if (out_a !== 6'd0)   begin bad++; $display("FAIL rst_outstanding got=%h exp=0", out_a); end
                total++; if (busy_a !== 2'b00) begin bad++; $display("FAIL rst_busy got=%b exp=00", busy_a); end
            end
            if (cyc == 8) begin
                total++; if (rcnt_a[7:0] !== 8'd1) begin bad++; $display("FAIL rst_reaccept got=%0d exp=1", rcnt_a[7:0]); end
                total++; if (out_a[2:0] !== 3'd1)  begin bad++; $display("FAIL rst_reaccept_out got=%0d exp=1", out_a[2:0]); end
            end
            next_cycle();
        end
        req_a = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_gap();
        test_two_channels();
        test_back_to_back();
        test_saturate_clear();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
